// File: rtl/sequenciador_servos_pkg.sv
// Shared types and default timing for the servo sequencer.
// Default timing assumes a 50 MHz clock and a 20 ms servo frame.
package sequenciador_servos_pkg;

  localparam int DB_ESTADO_W = 2;

  typedef enum logic [DB_ESTADO_W-1:0] {
    OCIOSO  = 2'd0,
    CARREGA = 2'd1,
    RAMPA   = 2'd2,
    ESPERA  = 2'd3
  } estado_t;

  localparam int PERIODO_PADRAO         = 1000000;
  localparam int LARGURA_MIN_PADRAO     = 50000;
  localparam int LARGURA_MAX_PADRAO     = 100000;
  localparam int LARGURA_INICIAL_PADRAO = 75000;
  localparam int PASSO_PADRAO           = 2500;
  localparam int ESPERA_CICLOS_PADRAO   = 25000000;

endpackage

// File: rtl/sequenciador_servos_if.sv
// Command push bus: the producer drives a strobe, channel and target width,
// and sees back-pressure through cheia.
interface sequenciador_servos_if #(
  parameter int CANAL_W   = 3,
  parameter int LARGURA_W = 20
) ();
  logic                 iniciar;
  logic [CANAL_W-1:0]   canal;
  logic [LARGURA_W-1:0] alvo;
  logic                 cheia;

  modport master (output iniciar, output canal, output alvo, input cheia);
  modport slave  (input iniciar, input canal, input alvo, output cheia);
endinterface

// File: rtl/sequenciador_servos_fifo_comandos.sv
// Small synchronous command FIFO; pushes while full and pops while empty
// are ignored.
module fifo_comandos #(
  parameter int LARGURA_DADO = 23,
  parameter int PROF         = 4,
  localparam int PTR_W       = $clog2(PROF),
  localparam int CNT_W       = PTR_W + 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [LARGURA_DADO-1:0] i_dado,
  output logic [LARGURA_DADO-1:0] o_dado,
  output logic                    o_cheia,
  output logic                    o_vazia,
  output logic [CNT_W-1:0]        o_count
);

  logic [LARGURA_DADO-1:0] r_mem [PROF];
  logic [PTR_W-1:0]        r_wr;
  logic [PTR_W-1:0]        r_rd;
  logic [CNT_W-1:0]        r_count;
  logic                    w_push;
  logic                    w_pop;

  assign o_cheia = (r_count == CNT_W'(PROF));
  assign o_vazia = (r_count == '0);
  assign o_count = r_count;
  assign o_dado  = r_mem[r_rd];
  assign w_push  = i_push && !o_cheia;
  assign w_pop   = i_pop && !o_vazia;

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= i_dado;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sequenciador_servos.sv
// N-channel servo sequencer: queued commands are executed in order as
// slew-limited ramps followed by a settle wait, with one PWM per channel.
//
//   state   | meaning
//   OCIOSO  | idle; pops the next command when the FIFO is non-empty
//   CARREGA | validates channel, clamps target width
//   RAMPA   | steps the latched channel toward target once per PWM period
//   ESPERA  | settle wait after the ramp, then back to OCIOSO
module sequenciador_servos
  import sequenciador_servos_pkg::*;
#(
  parameter int N_SERVOS        = 3,
  parameter int CANAL_W         = 3,
  parameter int LARGURA_W       = 20,
  parameter int PERIODO         = PERIODO_PADRAO,
  parameter int LARGURA_MIN     = LARGURA_MIN_PADRAO,
  parameter int LARGURA_MAX     = LARGURA_MAX_PADRAO,
  parameter int LARGURA_INICIAL = LARGURA_INICIAL_PADRAO,
  parameter int PASSO           = PASSO_PADRAO,
  parameter int ESPERA_CICLOS   = ESPERA_CICLOS_PADRAO,
  parameter int PROF_FILA       = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  sequenciador_servos_if.slave   bus,
  output logic                   pronto,
  output logic [N_SERVOS-1:0]    pwm,
  output logic [DB_ESTADO_W-1:0] db_estado,
  output logic                   db_erro
);

  localparam int CNT_W = $clog2(PROF_FILA) + 1;
  localparam logic [LARGURA_W-1:0] L_MIN   = LARGURA_W'(LARGURA_MIN);
  localparam logic [LARGURA_W-1:0] L_MAX   = LARGURA_W'(LARGURA_MAX);
  localparam logic [LARGURA_W-1:0] L_INI   = LARGURA_W'(LARGURA_INICIAL);
  localparam logic [LARGURA_W-1:0] L_PASSO = LARGURA_W'(PASSO);

  estado_t                r_estado;
  estado_t                w_estado_prox;
  logic [CANAL_W-1:0]     r_canal;
  logic [LARGURA_W-1:0]   r_alvo;
  logic [LARGURA_W-1:0]   r_contador;
  logic [LARGURA_W-1:0]   w_contador_prox;
  logic [LARGURA_W-1:0]   r_largura      [N_SERVOS];
  logic [LARGURA_W-1:0]   w_largura_prox [N_SERVOS];
  logic [31:0]            r_espera;
  logic                   r_erro;
  logic [N_SERVOS-1:0]    r_pwm;

  logic                   w_pop;
  logic                   w_vazia;
  logic                   w_cheia;
  logic [CNT_W-1:0]       w_count;
  logic [CANAL_W+LARGURA_W-1:0] w_cmd;
  logic                   w_fim_periodo;
  logic                   w_canal_valido;
  logic                   w_atualiza;
  logic [LARGURA_W-1:0]   w_atual;
  logic [LARGURA_W-1:0]   w_passo;
  logic [LARGURA_W-1:0]   w_alvo_limitado;

  fifo_comandos #(
    .LARGURA_DADO (CANAL_W + LARGURA_W),
    .PROF         (PROF_FILA)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (bus.iniciar),
    .i_pop   (w_pop),
    .i_dado  ({bus.canal, bus.alvo}),
    .o_dado  (w_cmd),
    .o_cheia (w_cheia),
    .o_vazia (w_vazia),
    .o_count (w_count)
  );

  assign bus.cheia      = w_cheia;
  assign pronto         = (r_estado == OCIOSO) && (w_count == '0);
  assign pwm            = r_pwm;
  assign db_estado      = r_estado;
  assign db_erro        = r_erro;
  assign w_fim_periodo  = (r_contador == LARGURA_W'(PERIODO - 1));
  assign w_contador_prox = w_fim_periodo ? '0 : r_contador + 1'b1;
  assign w_canal_valido = (32'(r_canal) < 32'(N_SERVOS));

  always_comb begin
    w_atual = L_INI;
    for (int i = 0; i < N_SERVOS; i++)
      if (r_canal == CANAL_W'(i)) w_atual = r_largura[i];
  end

  // Compare first, then subtract the smaller from the larger: no wrap.
  always_comb begin
    w_passo = w_atual;
    if (r_alvo > w_atual)
      w_passo = (r_alvo - w_atual <= L_PASSO) ? r_alvo : w_atual + L_PASSO;
    else if (r_alvo < w_atual)
      w_passo = (w_atual - r_alvo <= L_PASSO) ? r_alvo : w_atual - L_PASSO;
  end

  always_comb begin
    w_alvo_limitado = r_alvo;
    if (r_alvo < L_MIN)      w_alvo_limitado = L_MIN;
    else if (r_alvo > L_MAX) w_alvo_limitado = L_MAX;
  end

  always_comb begin
    w_estado_prox = r_estado;
    w_pop         = 1'b0;
    w_atualiza    = 1'b0;
    case (r_estado)
      OCIOSO: begin
        if (!w_vazia) begin
          w_pop         = 1'b1;
          w_estado_prox = CARREGA;
        end
      end
      CARREGA: w_estado_prox = w_canal_valido ? RAMPA : OCIOSO;
      RAMPA: begin
        if (w_atual == r_alvo)  w_estado_prox = ESPERA;
        else if (w_fim_periodo) w_atualiza    = 1'b1;
      end
      ESPERA:  if (r_espera == '0) w_estado_prox = OCIOSO;
      default: w_estado_prox = OCIOSO;
    endcase
  end

  always_comb begin
    for (int i = 0; i < N_SERVOS; i++) begin
      w_largura_prox[i] = r_largura[i];
      if (w_atualiza && (r_canal == CANAL_W'(i))) w_largura_prox[i] = w_passo;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado   <= OCIOSO;
      r_canal    <= '0;
      r_alvo     <= '0;
      r_espera   <= '0;
      r_erro     <= 1'b0;
      r_contador <= '0;
    end else begin
      r_estado   <= w_estado_prox;
      r_contador <= w_contador_prox;
      if (w_pop) {r_canal, r_alvo} <= w_cmd;
      if (r_estado == CARREGA) r_alvo <= w_alvo_limitado;
      if ((r_estado == RAMPA) && (w_estado_prox == ESPERA))
        r_espera <= 32'(ESPERA_CICLOS - 1);
      else if ((r_estado == ESPERA) && (r_espera != '0))
        r_espera <= r_espera - 1'b1;
      if ((bus.iniciar && w_cheia) || ((r_estado == CARREGA) && !w_canal_valido))
        r_erro <= 1'b1;
    end
  end

  // PWM is registered from next-cycle counter/width so it stays glitch-free
  // yet still equals (counter < width) in every cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_SERVOS; i++) r_largura[i] <= L_INI;
      r_pwm <= '1;
    end else begin
      for (int i = 0; i < N_SERVOS; i++) begin
        r_largura[i] <= w_largura_prox[i];
        r_pwm[i]     <= (w_contador_prox < w_largura_prox[i]);
      end
    end
  end

endmodule

// File: tb/tb_sequenciador_servos.sv
// Randomised bench for sequenciador_servos against a queue-based model.
module tb_sequenciador_servos;
  import sequenciador_servos_pkg::*;

  localparam int NS = 3, PER = 100, LMIN = 20, LMAX = 80, LINI = 50;
  localparam int PASSO = 10, ESP = 50, PROF = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       pronto;
  logic [2:0] pwm;
  logic [1:0] db_estado;
  logic       db_erro;

  sequenciador_servos_if #(.CANAL_W(3), .LARGURA_W(20)) bus ();

  sequenciador_servos #(
    .N_SERVOS(NS), .CANAL_W(3), .LARGURA_W(20), .PERIODO(PER),
    .LARGURA_MIN(LMIN), .LARGURA_MAX(LMAX), .LARGURA_INICIAL(LINI),
    .PASSO(PASSO), .ESPERA_CICLOS(ESP), .PROF_FILA(PROF)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .pronto(pronto),
    .pwm(pwm), .db_estado(db_estado), .db_erro(db_erro)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, esp, $time);
    end
  endtask

  // Reference model: phase 0 idle, 1 load, 2 ramp, 3 settle.
  int m_cont, m_fase, m_canal, m_alvo, m_esp;
  int m_larg [NS];
  int m_fila_c [$];
  int m_fila_a [$];
  bit m_erro;

  task automatic modelo(input bit rst, input bit ini, input int can, input int alv);
    bit cheia_antes;
    if (rst) begin
      m_cont = 0; m_fase = 0; m_esp = 0; m_erro = 0;
      m_canal = 0; m_alvo = 0;
      m_fila_c.delete(); m_fila_a.delete();
      for (int i = 0; i < NS; i++) m_larg[i] = LINI;
      return;
    end
    cheia_antes = (m_fila_c.size() == PROF);
    if (ini && cheia_antes) m_erro = 1;
    case (m_fase)
      0: if (m_fila_c.size() > 0) begin
           m_canal = m_fila_c.pop_front();
           m_alvo  = m_fila_a.pop_front();
           m_fase  = 1;
         end
      1: if (m_canal >= NS) begin
           m_erro = 1; m_fase = 0;
         end else begin
           if (m_alvo < LMIN) m_alvo = LMIN;
           if (m_alvo > LMAX) m_alvo = LMAX;
           m_fase = 2;
         end
      2: if (m_larg[m_canal] == m_alvo) begin
           m_fase = 3; m_esp = 0;
         end else if (m_cont == PER - 1) begin
           int d;
           d = m_alvo - m_larg[m_canal];
           if (d <= PASSO && d >= -PASSO) m_larg[m_canal] = m_alvo;
           else if (d > 0) m_larg[m_canal] += PASSO;
           else            m_larg[m_canal] -= PASSO;
         end
      default: if (m_esp == ESP - 1) m_fase = 0; else m_esp++;
    endcase
    if (ini && !cheia_antes) begin
      m_fila_c.push_back(can);
      m_fila_a.push_back(alv);
    end
    m_cont = (m_cont == PER - 1) ? 0 : m_cont + 1;
  endtask

  task automatic ciclo(input bit rst, input bit ini, input int can, input int alv);
    logic [31:0] pwm_esp;
    reset       = rst;
    bus.iniciar = ini;
    bus.canal   = 3'(can);
    bus.alvo    = 20'(alv);
    @(posedge clock);
    #1;
    modelo(rst, ini, can, alv);
    pwm_esp = '0;
    for (int i = 0; i < NS; i++) pwm_esp[i] = (m_cont < m_larg[i]);
    confere("pwm", {29'b0, pwm}, pwm_esp);
    confere("pronto", {31'b0, pronto}, {31'b0, (m_fase == 0 && m_fila_c.size() == 0)});
    confere("cheia", {31'b0, bus.cheia}, {31'b0, (m_fila_c.size() == PROF)});
    confere("db_estado", {30'b0, db_estado}, 32'(m_fase));
    confere("db_erro", {31'b0, db_erro}, {31'b0, m_erro});
  endtask

  task automatic ocioso(input int n);
    for (int k = 0; k < n; k++) ciclo(0, 0, 0, 0);
  endtask

  task automatic espera_pronto(input string tag, input int limite);
    for (int k = 0; k < limite; k++) begin
      if (pronto === 1'b1) break;
      ciclo(0, 0, 0, 0);
    end
    confere(tag, {31'b0, pronto}, 32'd1);
  endtask

  task automatic mede_alta(input string tag, input int ch, input int esp);
    int cnt;
    cnt = 0;
    for (int k = 0; k < PER; k++) begin
      ciclo(0, 0, 0, 0);
      cnt += int'(pwm[ch]);
    end
    confere(tag, 32'(cnt), 32'(esp));
  endtask

  initial begin
    bus.iniciar = 1'b0; bus.canal = '0; bus.alvo = '0;

    // 1: reset state and idle PWM
    ciclo(1, 0, 0, 0);
    ciclo(1, 0, 0, 0);
    confere("t1_pronto", {31'b0, pronto}, 32'd1);
    confere("t1_estado", {30'b0, db_estado}, 32'd0);
    mede_alta("t1_alta0", 0, LINI);

    // 2: ramp up channel 1
    ciclo(0, 1, 1, 80);
    espera_pronto("t2_pronto", 2000);
    mede_alta("t2_alta1", 1, 80);
    mede_alta("t2_alta0", 0, 50);
    mede_alta("t2_alta2", 2, 50);

    // 3: target below minimum is clamped
    ciclo(0, 1, 0, 5);
    espera_pronto("t3_pronto", 2000);
    mede_alta("t3_alta0", 0, LMIN);

    // 4: burst of five while busy, fifth is dropped
    ciclo(0, 1, 2, 30);
    ocioso(3);
    for (int k = 0; k < 5; k++)
      ciclo(0, 1, $urandom_range(0, 2), $urandom_range(0, 120));
    confere("t4_erro", {31'b0, db_erro}, 32'd1);
    espera_pronto("t4_pronto", 20000);

    // 5: invalid channel
    ciclo(1, 0, 0, 0);
    ciclo(0, 1, 3, 60);
    ocioso(3);
    confere("t5_estado", {30'b0, db_estado}, 32'd0);
    confere("t5_erro", {31'b0, db_erro}, 32'd1);
    mede_alta("t5_alta0", 0, LINI);

    // 6: reset mid-ramp
    ciclo(0, 1, 1, 80);
    for (int k = 0; k < 1000; k++) begin
      if (m_larg[1] == 70) break;
      ciclo(0, 0, 0, 0);
    end
    ciclo(1, 0, 0, 0);
    confere("t6_pronto", {31'b0, pronto}, 32'd1);
    confere("t6_cheia", {31'b0, bus.cheia}, 32'd0);
    mede_alta("t6_alta1", 1, LINI);

    // random traffic, including invalid channels and rare resets
    for (int k = 0; k < 4000; k++)
      ciclo(($urandom_range(0, 999) == 0), ($urandom_range(0, 29) == 0),
            $urandom_range(0, 3), $urandom_range(0, 127));
    espera_pronto("final_pronto", 20000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
